accum_rr_sched: RTL and testbench

- Round-robin scheduler that shares one WIDTH-bit accumulate datapath between NREQ requesters.
- Each accepted request runs a fixed 3-phase sequence (select, grant, accumulate), as in the single-requester accumulator FSM.
- Sits between requesting blocks and the shared running-sum register; drives the 8-bit LED view of the sum.

---
 rtl/accum_rr_sched.sv | 151 +++++++++++++++
 tb/tb_accum_rr_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_rr_sched.sv
// Round-robin scheduler sharing one accumulate datapath between NREQ requesters.
// Each accepted request runs select (IDLE) -> grant (GRANT) -> accumulate (ACC),
// so the shared running sum advances at most once every three cycles.
module accum_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_value,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [WIDTH-1:0]        count,
    output logic                    overflow,
    output logic [7:0]              led
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [IDW-1:0]    ptr_q,     ptr_d;
    logic [IDW-1:0]    sel_q,     sel_d;
    logic [WIDTH-1:0]  opnd_q,    opnd_d;
    logic [WIDTH-1:0]  count_q,   count_d;
    logic              ovf_q,     ovf_d;
    logic [NREQ-1:0]   gnt_q,     gnt_d;
    logic              done_q,    done_d;
    logic [IDW-1:0]    done_id_q, done_id_d;

    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [WIDTH-1:0]  win_val;
    logic [WIDTH:0]    add_full;
    logic [IDW-1:0]    ptr_nxt;

    // Rotating-priority pick: indices at or above ptr beat those below it, and
    // within each group the lowest index wins (later writes override earlier).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_val   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i < int'(ptr_q))) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
                win_val   = req_value[i*WIDTH +: WIDTH];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr_q))) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
                win_val   = req_value[i*WIDTH +: WIDTH];
            end
        end
    end

    assign add_full = {1'b0, count_q} + {1'b0, opnd_q};
    assign ptr_nxt  = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

    // Next-state logic: clr in any state clears the sum and abandons any
    // in-flight operation without moving the pointer or producing done.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        opnd_d    = opnd_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (win_found) begin
                    sel_d   = win_idx;
                    opnd_d  = win_val;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (clr) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (clr) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    count_d   = add_full[WIDTH-1:0];
                    ovf_d     = ovf_q | add_full[WIDTH];
                    done_d    = 1'b1;
                    done_id_d = sel_q;
                    ptr_d     = ptr_nxt;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            opnd_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            opnd_q    <= opnd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign led      = count_q[23:16];

endmodule

// File: tb/tb_accum_rr_sched.sv
// Directed bench for accum_rr_sched: inputs change and outputs are checked on
// the falling clock edge, so each tick is one full rising-edge cycle.
module tb_accum_rr_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                   CLK;
    logic                   RST;
    logic                   clr;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  req_value;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [WIDTH-1:0]       count;
    logic                   overflow;
    logic [7:0]             led;

    int checks;
    int failures;

    accum_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (clr),
        .req       (req),
        .req_value (req_value),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .count     (count),
        .overflow  (overflow),
        .led       (led)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_val(input int i, input logic [WIDTH-1:0] v);
        req_value[i*WIDTH +: WIDTH] = v;
    endtask

    // One lone-requester operation: grant seen, req dropped, done two cycles later.
    task automatic single_op(input int i, input logic [WIDTH-1:0] v);
        set_val(i, v);
        req = NREQ'(1) << i;
        tick();
        chk("single_gnt", gnt, NREQ'(1) << i);
        req = '0;
        tick();
        tick();
        chk("single_done", done, 1);
        chk("single_id", done_id, i);
    endtask

    // One round-robin step with req held high by everyone.
    task automatic rr_op(input int exp_id, input logic [WIDTH-1:0] exp_cnt);
        tick();
        chk("rr_gnt", gnt, NREQ'(1) << exp_id);
        chk("rr_nodone_with_gnt", done, 0);
        tick();
        chk("rr_gnt_drop", gnt, 0);
        tick();
        chk("rr_done", done, 1);
        chk("rr_id", done_id, exp_id);
        chk("rr_count", count, exp_cnt);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        RST       = 1'b0;
        clr       = 1'b0;
        req       = '0;
        req_value = '0;

        // Reset state
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_id", done_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", led, 0);
        RST = 1'b1;

        // Single request from requester 0, value 5
        set_val(0, 32'd5);
        req = 4'b0001;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_busy_grant", busy, 1);
        chk("t1_done_lo", done, 0);
        req = '0;
        tick();
        chk("t1_gnt_lo", gnt, 0);
        chk("t1_busy_acc", busy, 1);
        chk("t1_done_lo2", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_id", done_id, 0);
        chk("t1_count", count, 5);
        chk("t1_led", led, 0);
        chk("t1_busy_idle", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // Fresh reset, then all four requesting: order 0,1,2,3,0
        RST = 1'b0;
        tick();
        RST = 1'b1;
        set_val(0, 32'd1);
        set_val(1, 32'd2);
        set_val(2, 32'd3);
        set_val(3, 32'd4);
        req = 4'b1111;
        rr_op(0, 32'd1);
        rr_op(1, 32'd3);
        rr_op(2, 32'd6);
        rr_op(3, 32'd10);
        rr_op(0, 32'd11);
        req = '0;
        tick();
        chk("rr_idle_gnt", gnt, 0);

        // clr and req together in IDLE: clear wins, no grant
        clr = 1'b1;
        req = 4'b0001;
        tick();
        chk("clrreq_gnt", gnt, 0);
        chk("clrreq_busy", busy, 0);
        chk("clrreq_count", count, 0);
        clr = 1'b0;
        req = '0;

        // Wrap and sticky overflow
        single_op(0, 32'hFFFF_FFFE);
        chk("wrap_pre_count", count, 32'hFFFF_FFFE);
        chk("wrap_pre_ovf", overflow, 0);
        single_op(0, 32'd3);
        chk("wrap_count", count, 32'd1);
        chk("wrap_ovf", overflow, 1);
        single_op(0, 32'd1);
        chk("wrap2_count", count, 32'd2);
        chk("wrap2_ovf_sticky", overflow, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_ovf", overflow, 0);

        // LED view, then clr during GRANT drops the operation
        single_op(1, 32'h0012_0000);
        chk("led_val", led, 8'h12);
        set_val(1, 32'd50);
        req = 4'b0010;
        tick();
        chk("clrg_gnt", gnt, 4'b0010);
        req = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrg_busy", busy, 0);
        chk("clrg_count", count, 0);
        chk("clrg_led", led, 0);
        chk("clrg_done", done, 0);
        tick();
        chk("clrg_done2", done, 0);
        chk("clrg_gnt2", gnt, 0);

        // Operand latched at grant; held req gives a second grant with new value
        set_val(2, 32'd7);
        req = 4'b0100;
        tick();
        chk("latch_gnt1", gnt, 4'b0100);
        set_val(2, 32'd9);
        tick();
        tick();
        chk("latch_done1", done, 1);
        chk("latch_count1", count, 32'd7);
        tick();
        chk("latch_gnt2", gnt, 4'b0100);
        req = '0;
        tick();
        tick();
        chk("latch_done2", done, 1);
        chk("latch_count2", count, 32'd16);

        // Pointer now at 3; then reset during ACC
        set_val(0, 32'd1);
        set_val(1, 32'd2);
        set_val(2, 32'd3);
        set_val(3, 32'd4);
        req = 4'b1111;
        tick();
        chk("ptr_wrap_gnt", gnt, 4'b1000);
        req = '0;
        tick();
        chk("acc_busy", busy, 1);
        RST = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_gnt", gnt, 0);
        chk("arst_done", done, 0);
        tick();
        chk("arst_nodone", done, 0);
        RST = 1'b1;
        req = 4'b1111;
        tick();
        chk("arst_ptr0_gnt", gnt, 4'b0001);
        req = '0;
        tick();
        tick();
        chk("arst_done_id", done_id, 0);
        chk("arst_count1", count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
